// File: rtl/button_debouncer_if.sv
// Button signals between the pin/bus side and the debouncer.
// The bus side drives the raw pin and read strobe; the debouncer returns the conditioned level.
interface button_debouncer_if;
  logic btn_raw;
  logic btn_ren;
  logic btn_out;
  logic press_pulse;

  modport master (output btn_raw, output btn_ren, input btn_out, input press_pulse);
  modport slave  (input btn_raw, input btn_ren, output btn_out, output press_pulse);
endinterface

// File: rtl/button_debouncer.sv
// Push-button conditioner: synchronizer, counter-based debounce FSM and sticky press latch.
// btn_out: 1 = idle, 0 = pressed or a press not yet read by the CPU.
//
// state       | meaning
// RELEASED    | button accepted as released
// PRESS_CHK   | synced input low, waiting for it to stay low long enough
// PRESSED     | button accepted as pressed
// RELEASE_CHK | synced input high, waiting for it to stay high long enough
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic               clk,
  input  logic               reset,
  button_debouncer_if.slave  bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   pending_q, pending_d;
  logic                   level_d;
  logic                   accept;
  logic                   btn_out_q;
  logic                   pulse_q;

  assign s = sync_q[SYNC_STAGES-1];

  // Chain resets to 1 so a held button is seen only after the full sync delay.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], bus.btn_raw};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RELEASED;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      btn_out_q <= 1'b1;
      pulse_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      btn_out_q <= ~(level_d | pending_d);
      pulse_q   <= accept;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      RELEASED: begin
        if (!s) begin
          state_d = PRESS_CHK;
          cnt_d   = '0;
        end
      end
      PRESS_CHK: begin
        if (s) begin
          state_d = RELEASED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          accept  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (s) begin
          state_d = RELEASE_CHK;
          cnt_d   = '0;
        end
      end
      RELEASE_CHK: begin
        if (!s) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RELEASED;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = RELEASED;
    endcase
  end

  // A newly accepted press beats a read in the same cycle so it is never lost.
  always_comb begin
    level_d = (state_d == PRESSED) || (state_d == RELEASE_CHK);
    if (accept)           pending_d = 1'b1;
    else if (bus.btn_ren) pending_d = 1'b0;
    else                  pending_d = pending_q;
  end

  assign bus.btn_out     = btn_out_q;
  assign bus.press_pulse = pulse_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with DEBOUNCE_CYCLES=4, SYNC_STAGES=2 (latency 7 edges).
// Inputs change 1 ns after a rising edge; outputs are sampled at that same point.
module tb_button_debouncer;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  logic saw;

  button_debouncer_if bus_if ();

  button_debouncer #(
    .DEBOUNCE_CYCLES(4),
    .SYNC_STAGES    (2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic read_pulse();
    bus_if.btn_ren = 1'b1;
    tick();
    bus_if.btn_ren = 1'b0;
  endtask

  task automatic do_reset();
    bus_if.btn_raw = 1'b1;
    bus_if.btn_ren = 1'b0;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    bus_if.btn_raw = 1'b1;
    bus_if.btn_ren = 1'b0;
    #2;
    do_reset();

    check("rst_btn_out", bus_if.btn_out, 1'b1);
    check("rst_pulse", bus_if.press_pulse, 1'b0);

    read_pulse();
    check("idle_read", bus_if.btn_out, 1'b1);

    // Clean press: accepted on edge 7 after the first sampling edge.
    bus_if.btn_raw = 1'b0;
    tick(6);
    check("press_e6_out", bus_if.btn_out, 1'b1);
    check("press_e6_pulse", bus_if.press_pulse, 1'b0);
    tick();
    check("press_e7_out", bus_if.btn_out, 1'b0);
    check("press_e7_pulse", bus_if.press_pulse, 1'b1);
    tick();
    check("press_e8_pulse", bus_if.press_pulse, 1'b0);
    check("press_e8_out", bus_if.btn_out, 1'b0);
    bus_if.btn_raw = 1'b1;
    tick(12);
    check("press_release_sticky", bus_if.btn_out, 1'b0);
    read_pulse();
    check("press_read_clear", bus_if.btn_out, 1'b1);

    // Glitches of 1..4 cycles never reach the output.
    for (int g = 1; g <= 4; g++) begin
      saw = 1'b0;
      bus_if.btn_raw = 1'b0;
      for (int k = 0; k < g; k++) begin
        tick();
        saw |= bus_if.press_pulse | ~bus_if.btn_out;
      end
      bus_if.btn_raw = 1'b1;
      for (int k = 0; k < 10; k++) begin
        tick();
        saw |= bus_if.press_pulse | ~bus_if.btn_out;
      end
      check($sformatf("glitch_%0d", g), saw, 1'b0);
    end

    // Sticky press survives a long release until read.
    bus_if.btn_raw = 1'b0;
    tick(10);
    bus_if.btn_raw = 1'b1;
    tick(20);
    check("sticky_held", bus_if.btn_out, 1'b0);
    read_pulse();
    check("sticky_cleared", bus_if.btn_out, 1'b1);

    // Read on the acceptance edge: set wins.
    bus_if.btn_raw = 1'b0;
    tick(6);
    bus_if.btn_ren = 1'b1;
    tick();
    bus_if.btn_ren = 1'b0;
    check("simul_out", bus_if.btn_out, 1'b0);
    check("simul_pulse", bus_if.press_pulse, 1'b1);
    bus_if.btn_raw = 1'b1;
    tick(12);
    check("simul_pending_kept", bus_if.btn_out, 1'b0);
    read_pulse();
    check("simul_cleared", bus_if.btn_out, 1'b1);

    // Read while held: stays low until release is accepted 7 edges later.
    bus_if.btn_raw = 1'b0;
    tick(8);
    read_pulse();
    check("held_read_out", bus_if.btn_out, 1'b0);
    tick(3);
    bus_if.btn_raw = 1'b1;
    tick(6);
    check("held_rel_e6", bus_if.btn_out, 1'b0);
    tick();
    check("held_rel_e7", bus_if.btn_out, 1'b1);

    // Reset mid-PRESS_CHK acts without a clock edge, then full latency re-detect.
    bus_if.btn_raw = 1'b0;
    tick(4);
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid_chk", bus_if.btn_out, 1'b1);
    tick(2);
    reset = 1'b0;
    tick(6);
    check("redetect_e6", bus_if.btn_out, 1'b1);
    tick();
    check("redetect_e7", bus_if.btn_out, 1'b0);
    check("redetect_pulse", bus_if.press_pulse, 1'b1);

    // Reset with a pending press drops it immediately.
    bus_if.btn_raw = 1'b1;
    tick(10);
    check("pre_rst_pending", bus_if.btn_out, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("rst_drops_pending", bus_if.btn_out, 1'b1);
    tick(2);
    reset = 1'b0;
    tick(10);
    check("post_rst_idle", bus_if.btn_out, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
